// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer codecs.
package fifo_pkg;

  localparam int unsigned FIFO_NUM_BITS = 4;
  localparam int unsigned FIFO_DEPTH    = 16;

  // Codec working width; callers zero-extend narrower pointers and truncate the result.
  localparam int unsigned CODE_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary via an XOR prefix from the MSB down; zero upper bits leave the result intact.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b = g;
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // Metastability-settling stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost_full/level generator for the async FIFO (w_clk domain).
// Optional FIFO_WR_OVERFLOW_EN adds a sticky w_overflow flag with a w_ovf_clr input.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_BITS     = FIFO_NUM_BITS,
  parameter int unsigned DEPTH        = FIFO_DEPTH,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                w_en,
  input  logic [NUM_BITS:0]   rd_ptr_gray,
  output logic [NUM_BITS-1:0] w_ptr_bin,
  output logic [NUM_BITS:0]   w_ptr_gray,
  output logic                full,
  output logic                almost_full,
  output logic [NUM_BITS:0]   w_level
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  input  logic                w_ovf_clr,
  output logic                w_overflow
`endif
);

  localparam int unsigned PTR_W = NUM_BITS + 1;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_match;
  logic             push;

  // Bring the read pointer into w_clk; rq2 is its only consumer.
  sync_2ff #(
    .WIDTH(PTR_W)
  ) u_rsync (
    .clk  (w_clk),
    .rst_n(w_rst_n),
    .d    (rd_ptr_gray),
    .q    (rq2)
  );

  // Next pointer and flag terms; full/level look at wbin_next so full never lags a write.
  always_comb begin
    push       = w_en & ~full;
    wbin_next  = wbin + PTR_W'(push);
    wgray_next = PTR_W'(bin2gray(CODE_W'(wbin_next)));
    rbin_sync  = PTR_W'(gray2bin(CODE_W'(rq2)));
    level_next = wbin_next - rbin_sync;
    full_match = {~rq2[NUM_BITS:NUM_BITS-1], rq2[NUM_BITS-2:0]};
  end

  // Pointer and flag registers; w_ptr_gray is a bare flop so it can cross domains safely.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin        <= '0;
      w_ptr_gray  <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
    end else begin
      wbin        <= wbin_next;
      w_ptr_gray  <= wgray_next;
      full        <= (wgray_next == full_match);
      almost_full <= (level_next >= PTR_W'(DEPTH - AFULL_THRESH));
      w_level     <= level_next;
    end
  end

  assign w_ptr_bin = wbin[NUM_BITS-1:0];

`ifdef FIFO_WR_OVERFLOW_EN
  // Sticky record of a write dropped while full; a new drop beats a clear in the same cycle.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_overflow <= 1'b0;
    end else if (w_en && full) begin
      w_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      w_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: stimulus queues expected post-edge state, a monitor checks it.
module tb_fifo_wptr_full;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_en;
  logic [4:0] rd_ptr_gray;
  logic       w_ovf_clr;

  logic [3:0] w_ptr_bin,  w_ptr_bin4;
  logic [4:0] w_ptr_gray, w_ptr_gray4;
  logic       full,       full4;
  logic       almost_full, almost_full4;
  logic [4:0] w_level,    w_level4;
  logic       w_overflow, w_overflow4;

  fifo_wptr_full #(.NUM_BITS(4), .DEPTH(16), .AFULL_THRESH(2)) u_dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_en       (w_en),
    .rd_ptr_gray(rd_ptr_gray),
    .w_ptr_bin  (w_ptr_bin),
    .w_ptr_gray (w_ptr_gray),
    .full       (full),
    .almost_full(almost_full),
    .w_level    (w_level)
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    .w_ovf_clr  (w_ovf_clr),
    .w_overflow (w_overflow)
`endif
  );

  fifo_wptr_full #(.NUM_BITS(4), .DEPTH(16), .AFULL_THRESH(4)) u_dut4 (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_en       (w_en),
    .rd_ptr_gray(rd_ptr_gray),
    .w_ptr_bin  (w_ptr_bin4),
    .w_ptr_gray (w_ptr_gray4),
    .full       (full4),
    .almost_full(almost_full4),
    .w_level    (w_level4)
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    .w_ovf_clr  (w_ovf_clr),
    .w_overflow (w_overflow4)
`endif
  );

`ifndef FIFO_WR_OVERFLOW_EN
  assign w_overflow  = 1'b0;
  assign w_overflow4 = 1'b0;
`endif

  typedef struct {
    bit         c_ptr;
    logic [3:0] bin;
    logic [4:0] gray;
    bit         c_flag;
    logic       full;
    logic       af;
    logic       af4;
    bit         c_lvl;
    logic [4:0] lvl;
    bit         c_ovf;
    logic       ovf;
    bit         c_1bit;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk(input int wb, input int lvl, input logic f, input logic a, input logic a4);
    exp_t e;
    e.c_ptr  = 1'b1;
    e.bin    = 4'(wb % 16);
    e.gray   = g5(wb % 32);
    e.c_flag = 1'b1;
    e.full   = f;
    e.af     = a;
    e.af4    = a4;
    e.c_lvl  = 1'b1;
    e.lvl    = 5'(lvl);
    e.c_ovf  = 1'b0;
    e.ovf    = 1'b0;
    e.c_1bit = 1'b0;
    return e;
  endfunction

  function automatic exp_t with_ovf(input exp_t e0, input logic o);
    exp_t e;
    e = e0;
`ifdef FIFO_WR_OVERFLOW_EN
    e.c_ovf = 1'b1;
`endif
    e.ovf = o;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUTs must show after the following edge.
  task automatic step(input logic en, input logic [4:0] rd, input logic clr, input exp_t e, input string nm);
    @(negedge w_clk);
    w_en        = en;
    rd_ptr_gray = rd;
    w_ovf_clr   = clr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge w_clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".bin"},   32'(w_ptr_bin),   32'h0);
    chk({nm, ".gray"},  32'(w_ptr_gray),  32'h0);
    chk({nm, ".full"},  32'(full),        32'h0);
    chk({nm, ".af"},    32'(almost_full), 32'h0);
    chk({nm, ".lvl"},   32'(w_level),     32'h0);
    chk({nm, ".ovf"},   32'(w_overflow),  32'h0);
    chk({nm, ".gray4"}, 32'(w_ptr_gray4), 32'h0);
  endtask

  // Monitor: after every edge, pop one expectation if one was queued and compare.
  logic [4:0] prev_gray = 5'h0;
  always @(posedge w_clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.c_ptr) begin
        chk({nm, ".bin"},  32'(w_ptr_bin),  32'(e.bin));
        chk({nm, ".gray"}, 32'(w_ptr_gray), 32'(e.gray));
      end
      if (e.c_flag) begin
        chk({nm, ".full"},  32'(full),         32'(e.full));
        chk({nm, ".af"},    32'(almost_full),  32'(e.af));
        chk({nm, ".full4"}, 32'(full4),        32'(e.full));
        chk({nm, ".af4"},   32'(almost_full4), 32'(e.af4));
      end
      if (e.c_lvl) begin
        chk({nm, ".lvl"},  32'(w_level),  32'(e.lvl));
        chk({nm, ".lvl4"}, 32'(w_level4), 32'(e.lvl));
      end
      if (e.c_ovf) begin
        chk({nm, ".ovf"}, 32'(w_overflow), 32'(e.ovf));
      end
      if (e.c_1bit) begin
        chk({nm, ".gray_1bit"}, 32'($countones(w_ptr_gray ^ prev_gray)), 32'd1);
      end
    end
    prev_gray = w_ptr_gray;
  end

  initial begin
    int wait_cyc;
    exp_t e;
    w_en        = 1'b0;
    rd_ptr_gray = 5'h0;
    w_ovf_clr   = 1'b0;
    w_rst_n     = 1'b1;
    #2 w_rst_n  = 1'b0;
    #1 chk_zero("rst0");
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Fill to full with the read pointer parked at 0.
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 5'h0, 1'b0, mk(k, k, k == 16, k >= 14, k >= 12), "fill");
    end

    // Write while full is dropped; overflow flag sets, holds, then clears.
    step(1'b1, 5'h0, 1'b0, with_ovf(mk(16, 16, 1, 1, 1), 1'b1), "wfull");
    step(1'b0, 5'h0, 1'b0, with_ovf(mk(16, 16, 1, 1, 1), 1'b1), "ovfhold");
    step(1'b0, 5'h0, 1'b1, with_ovf(mk(16, 16, 1, 1, 1), 1'b0), "ovfclr");

    // One read seen by the write side only on the 3rd edge.
    step(1'b0, 5'b00001, 1'b0, with_ovf(mk(16, 16, 1, 1, 1), 1'b0), "rel1");
    step(1'b0, 5'b00001, 1'b0, mk(16, 16, 1, 1, 1), "rel2");
    step(1'b0, 5'b00001, 1'b0, mk(16, 15, 0, 1, 1), "rel3");

    // Refill the freed slot, then overrun to set the overflow flag before reset.
    step(1'b1, 5'b00001, 1'b0, mk(17, 16, 1, 1, 1), "prerst");
    step(1'b1, 5'b00001, 1'b0, with_ovf(mk(17, 16, 1, 1, 1), 1'b1), "prerst2");

    // Asynchronous reset between edges clears everything at once.
    #3 w_rst_n = 1'b0;
    w_en        = 1'b0;
    rd_ptr_gray = 5'h0;
    #1 chk_zero("rst_async");
    repeat (2) @(posedge w_clk);
    #1 chk_zero("rst_hold");
    @(negedge w_clk);
    w_rst_n = 1'b1;
    step(1'b0, 5'h0, 1'b0, with_ovf(mk(0, 0, 0, 0, 0), 1'b0), "idle");

    // 40 writes with reads trailing two behind: pointer wraps 31->0, level settles at 5.
    for (int j = 1; j <= 40; j++) begin
      e = mk(j, (j < 5) ? j : 5, 0, 0, 0);
      e.c_1bit = 1'b1;
      step(1'b1, (j >= 3) ? g5(j - 3) : 5'h0, 1'b0, e, "wrap");
    end

    @(negedge w_clk);
    w_en = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge w_clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
